// File: rtl/seg7_scan.sv
// seg7_scan: multiplexed seven-segment driver for NDIGITS hex digits.
// Digits are scanned one at a time. Each ON phase is preceded by a DEAD phase
// with all digits off, which keeps one digit from ghosting into the next.
// A new value is captured into a pending buffer and is copied to the active
// buffer only at a frame boundary, so a frame never shows a mix of old and new.
// Optional build macro SEG7_LZB_EN enables leading-zero blanking.
module seg7_scan #(
  parameter int NDIGITS        = 4,
  parameter int SCAN_DIV       = 50000,
  parameter int DEAD           = 500,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit DIG_ACTIVE_LOW = 1'b0
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [4*NDIGITS-1:0]   value,
  input  logic [NDIGITS-1:0]     dp,
  input  logic [NDIGITS-1:0]     blank,
  input  logic                   load,
  output logic [7:0]             seg,
  output logic [NDIGITS-1:0]     dig,
  output logic                   frame_done
);
  localparam int CMAX = (SCAN_DIV > DEAD) ? SCAN_DIV : DEAD;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int IW   = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;

  typedef enum logic {DEADT, ON} state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic                 on_last;

  logic [4*NDIGITS-1:0] pend_val_q, pend_val_d, act_val_q, act_val_d;
  logic [NDIGITS-1:0]   pend_dp_q, pend_dp_d, act_dp_q, act_dp_d;
  logic [NDIGITS-1:0]   pend_blank_q, pend_blank_d, act_blank_q, act_blank_d;
  logic                 pend_vld_q, pend_vld_d;

  logic [7:0]           seg_q, seg_d;
  logic [NDIGITS-1:0]   dig_q, dig_d;
  logic                 fd_q, fd_d;
  logic [3:0]           nib;
  logic [6:0]           dec;
  logic                 lzb;
`ifdef SEG7_LZB_EN
  logic                 lead;
`endif

  // Scan FSM: DEADT -> ON per digit, idx advances at the end of every ON.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    idx_d   = idx_q;
    on_last = 1'b0;
    case (state_q)
      DEADT: begin
        if (DEAD == 0 || cnt_q == CW'(DEAD - 1)) begin
          state_d = ON;
          cnt_d   = '0;
        end
      end
      ON: begin
        if (cnt_q == CW'(SCAN_DIV - 1)) begin
          on_last = 1'b1;
          cnt_d   = '0;
          idx_d   = (idx_q == IW'(NDIGITS - 1)) ? '0 : idx_q + IW'(1);
          state_d = (DEAD == 0) ? ON : DEADT;
        end
      end
    endcase
  end

  // Scan state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= DEADT;
      cnt_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
    end
  end

  // Double buffer: load fills pending; the frame_done cycle commits it, and
  // a load landing in that same cycle bypasses straight into the active copy.
  always_comb begin
    pend_val_d   = pend_val_q;
    pend_dp_d    = pend_dp_q;
    pend_blank_d = pend_blank_q;
    pend_vld_d   = pend_vld_q;
    act_val_d    = act_val_q;
    act_dp_d     = act_dp_q;
    act_blank_d  = act_blank_q;
    if (load) begin
      pend_val_d   = value;
      pend_dp_d    = dp;
      pend_blank_d = blank;
      pend_vld_d   = 1'b1;
    end
    if (fd_q) begin
      if (load) begin
        act_val_d   = value;
        act_dp_d    = dp;
        act_blank_d = blank;
      end else if (pend_vld_q) begin
        act_val_d   = pend_val_q;
        act_dp_d    = pend_dp_q;
        act_blank_d = pend_blank_q;
      end
      pend_vld_d = 1'b0;
    end
  end

  // Buffer registers; after reset every digit is blanked.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_val_q   <= '0;
      pend_dp_q    <= '0;
      pend_blank_q <= '1;
      pend_vld_q   <= 1'b0;
      act_val_q    <= '0;
      act_dp_q     <= '0;
      act_blank_q  <= '1;
    end else begin
      pend_val_q   <= pend_val_d;
      pend_dp_q    <= pend_dp_d;
      pend_blank_q <= pend_blank_d;
      pend_vld_q   <= pend_vld_d;
      act_val_q    <= act_val_d;
      act_dp_q     <= act_dp_d;
      act_blank_q  <= act_blank_d;
    end
  end

  // Decode the selected digit in lit polarity. Decoding from the next-active
  // value keeps a just-committed buffer visible even when DEAD is 0.
  always_comb begin
    nib = act_val_d[{idx_q, 2'b00} +: 4];
    dec = '0;
    case (nib)
      4'h0: dec = 7'h3F;  4'h1: dec = 7'h06;  4'h2: dec = 7'h5B;  4'h3: dec = 7'h4F;
      4'h4: dec = 7'h66;  4'h5: dec = 7'h6D;  4'h6: dec = 7'h7D;  4'h7: dec = 7'h07;
      4'h8: dec = 7'h7F;  4'h9: dec = 7'h6F;  4'hA: dec = 7'h77;  4'hB: dec = 7'h7C;
      4'hC: dec = 7'h39;  4'hD: dec = 7'h5E;  4'hE: dec = 7'h79;  4'hF: dec = 7'h71;
    endcase
    lzb = 1'b0;
`ifdef SEG7_LZB_EN
    // Walk down from the top digit; zeros stay blank until a nonzero nibble.
    lead = 1'b1;
    for (int i = NDIGITS - 1; i > 0; i--) begin
      if (act_val_d[4*i +: 4] != 4'h0) lead = 1'b0;
      if (lead && IW'(i) == idx_q) lzb = 1'b1;
    end
`endif
    seg_d = '0;
    dig_d = '0;
    fd_d  = on_last && (idx_q == IW'(NDIGITS - 1));
    if (state_q == ON) begin
      dig_d[idx_q] = 1'b1;
      if (!act_blank_d[idx_q]) seg_d = {act_dp_d[idx_q], lzb ? 7'h00 : dec};
    end
  end

  // Output registers hold lit polarity; reset makes them dark immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      seg_q <= '0;
      dig_q <= '0;
      fd_q  <= 1'b0;
    end else begin
      seg_q <= seg_d;
      dig_q <= dig_d;
      fd_q  <= fd_d;
    end
  end

  assign seg        = SEG_ACTIVE_LOW ? ~seg_q : seg_q;
  assign dig        = DIG_ACTIVE_LOW ? ~dig_q : dig_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_seg7_scan.sv
// Testbench for seg7_scan: random loads checked against a frame/slot model of
// the display (cycle arithmetic plus a history of loads).
module tb_seg7_scan;
  localparam int N     = 4;
  localparam int SD    = 4;
  localparam int DEAD  = 1;
  localparam int SLOT  = DEAD + SD;
  localparam int FRAME = N * SLOT;
  localparam logic [6:0] SEG_TAB [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        load = 1'b0;
  logic [15:0] value = '0;
  logic [3:0]  dp = '0;
  logic [3:0]  blank = '0;
  logic [7:0]  seg;
  logic [3:0]  dig;
  logic        frame_done;

  int nchk = 0;
  int nerr = 0;
  int cyc  = 0;   // cycles since reset release; cycle 0 precedes the first edge

  int          ld_c[$];
  logic [15:0] ld_v[$];
  logic [3:0]  ld_d[$];
  logic [3:0]  ld_b[$];
  logic [7:0]  es;
  logic [3:0]  ed;
  logic        ef;

  seg7_scan #(.NDIGITS(N), .SCAN_DIV(SD), .DEAD(DEAD),
              .SEG_ACTIVE_LOW(1'b1), .DIG_ACTIVE_LOW(1'b0)) dut (
    .clk(clk), .reset_n(reset_n), .value(value), .dp(dp), .blank(blank),
    .load(load), .seg(seg), .dig(dig), .frame_done(frame_done));

  always #5 clk = ~clk;

  // Expected outputs during cycle c. Output shows the scan position of cycle
  // c-1. Frame f displays the last load made in a cycle <= f*FRAME (frame 0
  // always shows the reset contents: everything blank).
  function automatic void model(input int c, output logic [7:0] s,
                                output logic [3:0] dg, output logic fd);
    int sc, f, p, d;
    logic [15:0] v;
    logic [3:0]  dpv, bl;
    logic [7:0]  lit;
    s = 8'hFF; dg = 4'h0; fd = 1'b0;
    if (c < 1) return;
    sc = c - 1;
    f  = sc / FRAME;
    p  = sc % FRAME;
    d  = p / SLOT;
    fd = (p == FRAME - 1);
    if ((p % SLOT) < DEAD) return;
    dg  = 4'(1 << d);
    v   = '0; dpv = '0; bl = 4'hF;
    if (f > 0)
      foreach (ld_c[i])
        if (ld_c[i] <= f * FRAME) begin v = ld_v[i]; dpv = ld_d[i]; bl = ld_b[i]; end
    lit = {dpv[d], SEG_TAB[v[4*d +: 4]]};
`ifdef SEG7_LZB_EN
    if (d > 0 && (v >> (4*d)) == 16'h0) lit[6:0] = 7'h00;
`endif
    if (bl[d]) lit = 8'h00;
    s = ~lit;
  endfunction

  task automatic do_load(input logic [15:0] v, input logic [3:0] d, input logic [3:0] b);
    value = v; dp = d; blank = b; load = 1'b1;
    ld_c.push_back(cyc); ld_v.push_back(v); ld_d.push_back(d); ld_b.push_back(b);
  endtask

  task automatic clear_hist();
    ld_c.delete(); ld_v.delete(); ld_d.delete(); ld_b.delete();
  endtask

  task automatic test_reset();
    reset_n = 1'b0; load = 1'b0;
    repeat (3) @(negedge clk);
    nchk++;
    if ({seg, dig, frame_done} !== {8'hFF, 4'h0, 1'b0}) begin
      nerr++;
      $display("FAIL reset_hold seg=%h dig=%b fd=%b want seg=ff dig=0000 fd=0", seg, dig, frame_done);
    end
    reset_n = 1'b1; cyc = 0; clear_hist();
    for (int k = 0; k < 2*FRAME + 1; k++) begin
      @(negedge clk); cyc++;
      model(cyc, es, ed, ef); nchk++;
      if ({seg, dig, frame_done} !== {es, ed, ef}) begin
        nerr++;
        $display("FAIL reset_scan cyc=%0d seg=%h/%h dig=%b/%b fd=%b/%b (got/want)", cyc, seg, es, dig, ed, frame_done, ef);
      end
    end
  endtask

  task automatic test_pattern();
    for (int k = 0; k < 3*FRAME; k++) begin
      @(negedge clk); cyc++; load = 1'b0;
      model(cyc, es, ed, ef); nchk++;
      if ({seg, dig, frame_done} !== {es, ed, ef}) begin
        nerr++;
        $display("FAIL pattern cyc=%0d seg=%h/%h dig=%b/%b fd=%b/%b (got/want)", cyc, seg, es, dig, ed, frame_done, ef);
      end
      if (k == 0) do_load(16'h12AF, 4'b0100, 4'b0000);
    end
  endtask

  task automatic test_multi_load();
    int n = 0;
    for (int k = 0; k < 4*FRAME; k++) begin
      @(negedge clk); cyc++; load = 1'b0;
      model(cyc, es, ed, ef); nchk++;
      if ({seg, dig, frame_done} !== {es, ed, ef}) begin
        nerr++;
        $display("FAIL multi_load cyc=%0d seg=%h/%h dig=%b/%b fd=%b/%b (got/want)", cyc, seg, es, dig, ed, frame_done, ef);
      end
      if (n == 0 && cyc % FRAME == 5)       begin do_load(16'h1111, 4'h0, 4'h0); n = 1; end
      else if (n == 1 && cyc % FRAME == 11) begin do_load(16'h2222, 4'h0, 4'h0); n = 2; end
    end
  endtask

  task automatic test_boundary_load();
    int done = 0;
    for (int k = 0; k < 3*FRAME; k++) begin
      @(negedge clk); cyc++; load = 1'b0;
      model(cyc, es, ed, ef); nchk++;
      if ({seg, dig, frame_done} !== {es, ed, ef}) begin
        nerr++;
        $display("FAIL boundary cyc=%0d seg=%h/%h dig=%b/%b fd=%b/%b (got/want)", cyc, seg, es, dig, ed, frame_done, ef);
      end
      if (done == 0 && cyc % FRAME == 0) begin
        nchk++;
        if (frame_done !== 1'b1) begin
          nerr++;
          $display("FAIL boundary_pulse cyc=%0d frame_done=%b want 1", cyc, frame_done);
        end
        do_load(16'($urandom), 4'($urandom), 4'h0);
        done = 1;
      end
    end
  endtask

  task automatic test_reset_mid();
    int hit = 0;
    for (int k = 0; k < 3*FRAME && hit == 0; k++) begin
      @(negedge clk); cyc++; load = 1'b0;
      model(cyc, es, ed, ef); nchk++;
      if ({seg, dig, frame_done} !== {es, ed, ef}) begin
        nerr++;
        $display("FAIL pre_reset cyc=%0d seg=%h/%h dig=%b/%b fd=%b/%b (got/want)", cyc, seg, es, dig, ed, frame_done, ef);
      end
      if (k == 0) do_load(16'h8888, 4'hF, 4'h0);
      // Output in this cycle shows digit 2 mid-ON.
      if (k >= FRAME && (cyc - 1) % FRAME == 2*SLOT + DEAD + 1) hit = 1;
    end
    #2 reset_n = 1'b0;
    #1 nchk++;
    if ({seg, dig, frame_done} !== {8'hFF, 4'h0, 1'b0}) begin
      nerr++;
      $display("FAIL async_reset seg=%h dig=%b fd=%b want seg=ff dig=0000 fd=0", seg, dig, frame_done);
    end
    load = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1; cyc = 0; clear_hist();
    for (int k = 0; k < FRAME + SLOT + 2; k++) begin
      @(negedge clk); cyc++;
      model(cyc, es, ed, ef); nchk++;
      if ({seg, dig, frame_done} !== {es, ed, ef}) begin
        nerr++;
        $display("FAIL rescan cyc=%0d seg=%h/%h dig=%b/%b fd=%b/%b (got/want)", cyc, seg, es, dig, ed, frame_done, ef);
      end
    end
  endtask

  task automatic test_lzb();
    for (int k = 0; k < 6*FRAME; k++) begin
      @(negedge clk); cyc++; load = 1'b0;
      model(cyc, es, ed, ef); nchk++;
      if ({seg, dig, frame_done} !== {es, ed, ef}) begin
        nerr++;
        $display("FAIL lzb cyc=%0d seg=%h/%h dig=%b/%b fd=%b/%b (got/want)", cyc, seg, es, dig, ed, frame_done, ef);
      end
      if (k == 0)            do_load(16'h0050, 4'h0, 4'h0);
      else if (k == 2*FRAME) do_load(16'h0000, 4'h0, 4'h0);
      else if (k == 4*FRAME) do_load(16'h0300, 4'b0100, 4'h0);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 10*FRAME; k++) begin
      @(negedge clk); cyc++; load = 1'b0;
      model(cyc, es, ed, ef); nchk++;
      if ({seg, dig, frame_done} !== {es, ed, ef}) begin
        nerr++;
        $display("FAIL random cyc=%0d seg=%h/%h dig=%b/%b fd=%b/%b (got/want)", cyc, seg, es, dig, ed, frame_done, ef);
      end
      if ($urandom_range(0, 7) == 0 || (cyc % FRAME == 0 && $urandom_range(0, 1) == 0))
        do_load(16'($urandom), 4'($urandom),
                ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0);
    end
  endtask

  initial begin
    test_reset();
    test_pattern();
    test_multi_load();
    test_boundary_load();
    test_reset_mid();
    test_lzb();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
